// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered char store.
// Optional macro SEG_SCAN_LZ_BLANK_EN: blank leading zeros when a frame is committed.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYC        = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    pending,
  output logic [3:0]              char,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   buffer;
  logic [NUM_DIGITS-1:0][3:0]   shadow;
  logic [NUM_DIGITS-1:0][3:0]   commit_val;
  logic [NUM_DIGITS-1:0]        onehot;
  logic [NUM_DIGITS-1:0]        en_active;
  logic                         presc_wrap;
  logic                         commit_edge;

  assign presc_wrap  = (presc == PW'(SCAN_DIV - 1));
  assign commit_edge = presc_wrap && (idx == IW'(NUM_DIGITS - 1));
  assign onehot      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  assign en_active   = ANODE_ACTIVE_LOW ? ~onehot : onehot;

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Zeros above the most significant non-zero nibble become blank; digit 0 always shows.
  always_comb begin
    logic suppress;
    suppress   = 1'b1;
    commit_val = buffer;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (suppress && (buffer[i] == 4'h0)) commit_val[i] = 4'hF;
      else suppress = 1'b0;
    end
  end
`else
  assign commit_val = buffer;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      buffer     <= {NUM_DIGITS{4'hF}};
      shadow     <= {NUM_DIGITS{4'hF}};
      pending    <= 1'b0;
      char       <= 4'hF;
      digit_en   <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
      frame_tick <= 1'b0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

      frame_tick <= commit_edge;
      if (commit_edge && pending) begin
        shadow  <= commit_val;
        pending <= 1'b0;
      end
      // A load on the commit edge lands after the commit, so pending stays set.
      if (load) begin
        buffer  <= data_in;
        pending <= 1'b1;
      end

      // char and enable both register from the same state, so they switch together.
      char     <= shadow[idx];
      digit_en <= (presc >= PW'(BLANK_CYC)) ? en_active : {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    end
  end

endmodule
